lane_scheduler: RTL and testbench
=================================

// Module: lane_scheduler
// PURPOSE
//   Round-robin burst scheduler that shares one 8-bit output byte stream among four 8-bit input lanes.
//   Sits upstream of the lane serializer path and runs in the clk_4f domain.
//   It grants one lane at a time, moves up to MAX_BURST beats from that lane over a valid/ready handshake, then rotates.
//   The output byte is registered and accepts downstream backpressure.
// PARAMETERS
//   MAX_BURST  4  max beats per grant; legal range 1..16; beat counter is 4 bits
// PORTS
//   clk_4f          in   1  single clock, rising edge
//   reset           in   1  synchronous, active-high
//   Entrada0..3     in   8  lane data bytes
//   validEntrada0..3 in  1  lane has a byte available
//   ready0..3       out  1  lane byte taken this cycle (combinational)
//   Salida          out  8  scheduled output byte (registered)
//   validsalida     out  1  Salida holds a valid byte
//   readySalida     in   1  downstream consumes Salida this cycle
//   grant           out  2  index of the granted lane (registered)
//   active          out  1  1 = BURST state; grant is meaningful
// BEHAVIOUR
//   Reset values: state=IDLE, ptr=0, grant=0, active=0, beat_cnt=0, Salida=8'h00, validsalida=0.
//   Reset applies every cycle it is high.
//   can_acc = !validsalida | readySalida.
//   ready_i = active & (grant==i) & validEntrada_i & can_acc; all other ready outputs are 0.
//   Transfer: a cycle with ready_g=1. On the next edge Salida<=Entrada_g and validsalida<=1.
//     Latency is 1 cycle from accept to output.
//   No transfer and readySalida=1: validsalida<=0; Salida holds its last value.
//   No transfer and readySalida=0: Salida and validsalida hold.
//   IDLE:
//     - Search lanes ptr, ptr+1, ... (mod 4) for the first with validEntrada=1.
//     - If a lane is found: grant<=lane, beat_cnt<=0, go to BURST.
//     - If none: stay in IDLE.
//     - The search cycle is a bubble; no transfer happens in IDLE.
//   BURST, in priority order:
//     - validEntrada_g=0: go to IDLE, ptr<=grant+1.
//     - Transfer with beat_cnt==MAX_BURST-1: go to IDLE, ptr<=grant+1.
//     - Other transfer: beat_cnt<=beat_cnt+1.
//     - Stall (can_acc=0, valid=1): hold state and beat_cnt.
//   Grants are never preempted mid-burst.
//   ptr wraps 3 to 0. MAX_BURST=1 gives one beat per grant.
//   Reset mid-burst: the registered byte is dropped, and the lane's current byte stays un-acked (ready=0).
//   Simultaneous transfer-out and transfer-in: the new byte replaces the old one with no bubble, giving full throughput within a burst.
// CONFIGURATION
//   LANE0_PRIO_EN defined:
//     - In IDLE, lane 0 wins whenever validEntrada0=1, regardless of ptr.
//     - ptr still updates to grant+1 on release.
//     - Bursts of lanes 1-3 are not preempted.
//   LANE0_PRIO_EN undefined: pure round-robin as above.
// TESTING
//   1. Hold reset 2 cycles with all valids=1.
//      -> Salida=0, validsalida=0, active=0, grant=0, all ready=0.
//   2. All lanes valid, readySalida=1, MAX_BURST=4, lane i sends 8'hi0..8'hi3.
//      -> Bursts in grant order 0,1,2,3,0, each 4 bytes back-to-back.
//      -> 1 idle cycle between bursts.
//      -> Salida sequence: 00,01,02,03,10,...
//   3. Only lane 2 valid for 2 cycles (bytes A5, 5A), then it drops.
//      -> grant=2; Salida A5 then 5A.
//      -> active falls the cycle after valid drops; ptr=3.
//   4. Lane 1 in burst, readySalida=0 for 3 cycles after the first byte.
//      -> Salida holds the byte; ready1=0; beat_cnt unchanged.
//      -> The burst resumes with no byte lost or duplicated.
//   5. reset=1 for 1 cycle mid-burst on lane 3.
//      -> Next cycle: active=0, validsalida=0, ptr=0.
//      -> The lane 3 byte is re-sent after re-arbitration.
//   6. ptr=3 (after a lane 2 burst), lanes 0 and 3 valid.
//      -> With LANE0_PRIO_EN: grant=0.
//      -> Without it: grant=3.

Source files
------------

// File: rtl/lane_scheduler.sv
// Round-robin burst arbiter: four 8-bit lanes -> one registered byte stream, 1-cycle accept-to-output, stalls lanes when Salida is held.
// Optional LANE0_PRIO_EN: lane 0 wins every arbitration it participates in; default build is pure round-robin.
module lane_scheduler #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] Entrada0,
  input  logic [7:0] Entrada1,
  input  logic [7:0] Entrada2,
  input  logic [7:0] Entrada3,
  input  logic       validEntrada0,
  input  logic       validEntrada1,
  input  logic       validEntrada2,
  input  logic       validEntrada3,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  output logic [7:0] Salida,
  output logic       validsalida,
  input  logic       readySalida,
  output logic [1:0] grant,
  output logic       active
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [3:0][7:0] lane_dat;
  logic [3:0]      lane_vld;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] beat_q, beat_d;
  logic [7:0] dat_q, dat_d;
  logic       vld_q, vld_d;

  logic       can_acc;
  logic       sel_vld;
  logic       xfer;
  logic       found;
  logic [1:0] pick;

  assign lane_dat = {Entrada3, Entrada2, Entrada1, Entrada0};
  assign lane_vld = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};

  assign can_acc = !vld_q || readySalida;
  assign sel_vld = lane_vld[grant_q];
  // Reset gates the handshake so a lane byte in flight during reset is never acked.
  assign xfer    = (state_q == BURST) && sel_vld && can_acc && !reset;

  always_comb begin
    found = |lane_vld;
    pick  = ptr_q;
    // Walk offsets from farthest to nearest so the lane closest to ptr wins.
    for (int k = 3; k >= 0; k--) begin
      if (lane_vld[ptr_q + 2'(k)]) begin
        pick = ptr_q + 2'(k);
      end
    end
`ifdef LANE0_PRIO_EN
    if (lane_vld[0]) begin
      pick = 2'd0;
    end
`else
`endif
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      beat_q  <= 4'd0;
      dat_q   <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    dat_d   = dat_q;
    vld_d   = vld_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          grant_d = pick;
          beat_d  = 4'd0;
        end
      end
      BURST: begin
        if (!sel_vld) begin
          state_d = IDLE;
          ptr_d   = grant_q + 2'd1;
        end else if (xfer) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            ptr_d   = grant_q + 2'd1;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new byte overwrites the one being drained in the same cycle, so bursts run gap-free.
    if (xfer) begin
      dat_d = lane_dat[grant_q];
      vld_d = 1'b1;
    end else if (readySalida) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    active      = (state_q == BURST);
    grant       = grant_q;
    Salida      = dat_q;
    validsalida = vld_q;
    ready0      = xfer && (grant_q == 2'd0);
    ready1      = xfer && (grant_q == 2'd1);
    ready2      = xfer && (grant_q == 2'd2);
    ready3      = xfer && (grant_q == 2'd3);
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler: lanes are byte queues, expected output order is queued up front.
module tb_lane_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lane_dat [4];
  logic       lane_vld [4];
  logic       ready0, ready1, ready2, ready3;
  logic [7:0] Salida;
  logic       validsalida;
  logic       readySalida = 1'b1;
  logic [1:0] grant;
  logic       active;
  logic [3:0] rdy;

  logic [7:0] lq [4][$];
  logic [7:0] exp_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  assign rdy = {ready3, ready2, ready1, ready0};

  always #5 clk_4f = ~clk_4f;

  lane_scheduler #(.MAX_BURST(4)) dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .Entrada0      (lane_dat[0]),
    .Entrada1      (lane_dat[1]),
    .Entrada2      (lane_dat[2]),
    .Entrada3      (lane_dat[3]),
    .validEntrada0 (lane_vld[0]),
    .validEntrada1 (lane_vld[1]),
    .validEntrada2 (lane_vld[2]),
    .validEntrada3 (lane_vld[3]),
    .ready0        (ready0),
    .ready1        (ready1),
    .ready2        (ready2),
    .ready3        (ready3),
    .Salida        (Salida),
    .validsalida   (validsalida),
    .readySalida   (readySalida),
    .grant         (grant),
    .active        (active)
  );

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      lane_vld[i] = (lq[i].size() > 0);
      lane_dat[i] = (lq[i].size() > 0) ? lq[i][0] : 8'h00;
    end
  endtask

  // One clock: consume/score output and sample lane handshakes at negedge, then advance lane sources.
  task automatic step();
    logic [3:0] took;
    logic [7:0] eb;
    @(negedge clk_4f);
    took = rdy;
    if (validsalida === 1'b1 && readySalida === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %02h, required no output", Salida);
      end else begin
        eb = exp_q.pop_front();
        if (Salida !== eb) begin
          bad++;
          $display("FAIL sb_data: got %02h, required %02h", Salida, eb);
        end
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    @(posedge clk_4f);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (took[i] === 1'b1 && lq[i].size() > 0) void'(lq[i].pop_front());
    end
    drive();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    readySalida = 1'b1;
    for (int i = 0; i < 4; i++) lq[i].push_back(8'hEE);
    drive();
    step();
    step();
    total++; if (Salida !== 8'h00) begin bad++; $display("FAIL rst_salida: got %02h, required 00", Salida); end
    total++; if (validsalida !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", validsalida); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active: got %b, required 0", active); end
    total++; if (grant !== 2'd0) begin bad++; $display("FAIL rst_grant: got %0d, required 0", grant); end
    total++; if (rdy !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b, required 0000", rdy); end
    for (int i = 0; i < 4; i++) lq[i].delete();
    drive();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) begin
        lq[i].push_back(8'((i << 4) | b));
        exp_q.push_back(8'((i << 4) | b));
      end
    end
    for (int b = 4; b < 8; b++) begin
      lq[0].push_back(8'(b));
      exp_q.push_back(8'(b));
    end
    first_cyc = -1;
    drive();
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) step();
    repeat (3) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_drain: got %0d left, required 0", exp_q.size()); end
    // 20 back-to-back beats plus one arbitration bubble between each of the 5 bursts.
    total++; if (last_cyc - first_cyc != 23) begin bad++; $display("FAIL rr_span: got %0d cycles, required 23", last_cyc - first_cyc); end
  endtask

  task automatic test_single_lane();
    int  act_cnt;
    bit  gchk;
    act_cnt = 0;
    gchk = 1'b0;
    lq[2].push_back(8'hA5);
    lq[2].push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    drive();
    for (int n = 0; n < 10; n++) begin
      step();
      if (active === 1'b1) begin
        act_cnt++;
        if (!gchk) begin
          gchk = 1'b1;
          total++; if (grant !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d, required 2", grant); end
        end
      end
    end
    total++; if (act_cnt != 3) begin bad++; $display("FAIL single_active: got %0d cycles, required 3", act_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_ptr_priority();
    logic [1:0] exp_g;
    bit         seen;
    seen = 1'b0;
    lq[0].push_back(8'h0C);
    lq[3].push_back(8'h3C);
`ifdef LANE0_PRIO_EN
    exp_g = 2'd0;
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h3C);
`else
    exp_g = 2'd3;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h0C);
`endif
    drive();
    for (int n = 0; n < 5 && !seen; n++) begin
      step();
      if (active === 1'b1) seen = 1'b1;
    end
    total++; if (grant !== exp_g || !seen) begin bad++; $display("FAIL prio_grant: got %0d (active seen %0b), required %0d", grant, seen, exp_g); end
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) step();
    repeat (3) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL prio_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      lq[1].push_back(8'(8'h40 + b));
      exp_q.push_back(8'(8'h40 + b));
    end
    readySalida = 1'b1;
    first_cyc = -1;
    drive();
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (validsalida === 1'b1) seen = 1'b1;
    end
    readySalida = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (Salida !== 8'h41 || validsalida !== 1'b1) begin bad++; $display("FAIL bp_hold: got %02h/%b, required 41/1", Salida, validsalida); end
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL bp_ready1: got %b, required 0", ready1); end
      step();
    end
    readySalida = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) step();
    repeat (3) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d left, required 0", exp_q.size()); end
    // The stall must not consume beat budget: all four bytes leave back-to-back.
    total++; if (last_cyc - first_cyc != 3) begin bad++; $display("FAIL bp_span: got %0d cycles, required 3", last_cyc - first_cyc); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    seen = 1'b0;
    for (int b = 0; b < 4; b++) lq[3].push_back(8'(8'h3A + b));
    drive();
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (validsalida === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    readySalida = 1'b0;
    #1;
    total++; if (ready3 !== 1'b0) begin bad++; $display("FAIL rmb_ready3: got %b, required 0", ready3); end
    step();
    reset = 1'b0;
    readySalida = 1'b1;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rmb_active: got %b, required 0", active); end
    total++; if (validsalida !== 1'b0 || Salida !== 8'h00) begin bad++; $display("FAIL rmb_out: got %02h/%b, required 00/0", Salida, validsalida); end
    // ptr is back at 0, so lane 1 must win over lane 3 at the next arbitration.
    lq[1].push_back(8'h1F);
    exp_q.push_back(8'h1F);
    exp_q.push_back(8'h3B);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3D);
    drive();
    for (int n = 0; n < 30 && exp_q.size() > 0; n++) step();
    repeat (3) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rmb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      lane_dat[i] = 8'h00;
      lane_vld[i] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_single_lane();
    test_ptr_priority();
    test_backpressure();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
